ahb_master_engine: RTL and testbench
====================================

Name: ahb_master_engine

Overview:
- AHB-Lite initiator that drives the bridge's AHB slave interface (hwrite/htrans/haddr/hwdata out, hready/hresp/hrdata in).
- Converts one local command (address, direction, beat count) into a single or incrementing word burst with pipelined address/data phases.
- Honours wait states and two-cycle ERROR responses, streams write data in, returns read data out.
- Used as the stimulus master in bridge subsystem tests and as the CPU-side port in the top level.

Parameters:
LEN_W, 5, width of cmd_len; max burst = 2^LEN_W - 1 beats
TIMEOUT_CYC, 256, wait-state limit, used only with AHB_MASTER_TIMEOUT_EN

Ports:
hclk  input  1  clock; all logic rising-edge
hreset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  high only in IDLE state
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  32  start address, word aligned
cmd_len  input  LEN_W  beat count; 0 treated as 1
wd_data  input  32  write data for the beat currently in address phase
wd_pop  output  1  combinational; write beat address phase accepted, advance wd_data
rd_valid  output  1  registered read beat strobe
rd_data  output  32  registered read data
done  output  1  one-cycle pulse at command completion
err  output  1  one-cycle pulse with done if ERROR/timeout terminated burst
haddr  output  32  AHB address
htrans  output  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY never issued)
hwrite  output  1  AHB direction
hsize  output  3  constant 3'b010
hburst  output  3  SINGLE=000 if len 1, INCR4=011 if len 4, else INCR=001
hwdata  output  32  write data, driven in data phase
hready  input  1  slave ready
hresp  input  2  OKAY=00, ERROR=01
hrdata  input  32  read data

Behaviour:
- Reset: haddr=0, htrans=IDLE, hwrite=0, hburst=0, hwdata=0, rd_valid=0, rd_data=0, done=0, err=0, state IDLE. Reset mid-burst abandons the burst at the next edge; no done.
- States: IDLE, ADDR (address phase active, data phase of previous beat may overlap), LAST (data phase only), ERR2 (second ERROR cycle).
- IDLE: cmd_valid&cmd_ready at edge T latches command. T+1: htrans=NONSEQ, haddr=cmd_addr, hwrite, hburst set; state ADDR.
- Beat accepted when hready=1 and htrans is NONSEQ or SEQ. On that edge, haddr+=4 (mod 2^32, no 1 KB check), htrans=SEQ, remaining count decrements. For writes, hwdata<=wd_data and wd_pop=1 in the same cycle.
- After the last beat is accepted: htrans=IDLE, state LAST.
- hready=0: haddr, htrans, hwrite, hburst and hwdata all hold.
- Reads: data phase completes with hready=1 and hresp=OKAY; next cycle rd_valid=1 with rd_data equal to the captured hrdata.
- LAST: hready=1 with OKAY → done=1 next cycle, state IDLE. cmd_ready rises in the same cycle as done. Earliest new command is accepted on that cycle.
- Error, first cycle (hresp=ERROR, hready=0): next edge forces htrans=IDLE and cancels all remaining beats; an address already presented is not counted. State ERR2.
- Error, second cycle (ERR2, hready=1): done=1 and err=1 next cycle, state IDLE. No rd_valid for the errored beat.
- cmd inputs are ignored outside IDLE.

Optional Feature:
- Macro AHB_MASTER_TIMEOUT_EN, when defined:
  - Counter of consecutive hready=0 cycles while a transfer is outstanding; cleared when hready=1.
  - Reaching TIMEOUT_CYC forces htrans=IDLE, done=1 and err=1, state IDLE.
  - Adds output port timeout (1 bit), pulsing with that err.
- Macro undefined: no counter, no timeout port; the engine waits indefinitely.

Decomposition:
- Package ahb_pkg: HTRANS_IDLE/NONSEQ/SEQ, HBURST_SINGLE/INCR/INCR4, HRESP_OKAY/ERROR, HSIZE_WORD, state encodings.
- No sub-module; the timeout counter stays inline under the macro.

Test Plan:
- Single write: addr 0x0000_0010, len 1, wd 0xA5A5_0001, hready=1 → NONSEQ/SINGLE at T+1, hwdata 0xA5A5_0001 at T+2, done at T+3.
- INCR4 read: addr 0x8400_0000, hready low 2 cycles on beat 2 → haddr 0x8400_0000..0C, address holds during the waits, 4 rd_valid in order, done, err=0.
- ERROR on beat 2 of len 8 write at 0x8800_0000 → htrans IDLE after the first ERROR cycle, done+err, wd_pop count 2 or 3 (no further beats).
- Wrap: addr 0xFFFF_FFFC, len 2 → second haddr 0x0000_0000, hburst INCR.
- len 0 behaves as len 1 (hburst SINGLE). hreset asserted mid-burst → htrans IDLE next edge, no done.
- With AHB_MASTER_TIMEOUT_EN, TIMEOUT_CYC=8, hready stuck low → timeout, err, done pulse after 8 cycles.

Source files
------------

// File: rtl/ahb_master_engine_pkg.sv
// Shared AHB-Lite encodings and engine state type for ahb_master_engine.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_LAST = 2'b10,
    ST_ERR2 = 2'b11
  } state_e;

  // Burst encoding for an effective (non-zero) beat count.
  function automatic logic [2:0] burst_for_len(input logic [31:0] len);
    logic [2:0] b;
    case (len)
      32'd1:   b = HBURST_SINGLE;
      32'd4:   b = HBURST_INCR4;
      default: b = HBURST_INCR;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ahb_master_engine_if.sv
// AHB-Lite bus bundle between the engine (master) and a slave.
interface ahb_master_engine_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_master_engine.sv
// AHB-Lite initiator: one local command becomes a SINGLE/INCR/INCR4 word burst.
// Optional wait-state timeout enabled by defining AHB_MASTER_TIMEOUT_EN.
module ahb_master_engine
  import ahb_pkg::*;
#(
  parameter int LEN_W       = 5,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [31:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       wd_data,
  output logic              wd_pop,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              err,
`ifdef AHB_MASTER_TIMEOUT_EN
  output logic              timeout,
`endif
  ahb_master_engine_if.master ahb
);

  state_e             state_q, state_d;
  logic [31:0]        haddr_q, haddr_d;
  logic [1:0]         htrans_q, htrans_d;
  logic               hwrite_q, hwrite_d;
  logic [2:0]         hburst_q, hburst_d;
  logic [31:0]        hwdata_q, hwdata_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               dphase_q, dphase_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cmd_fire;
  logic               beat_acc;
  logic               dph_ok;
  logic               err1;
  logic               to_hit;
  logic [LEN_W-1:0]   len_eff;

  assign cmd_fire = cmd_valid && (state_q == ST_IDLE);
  assign beat_acc = ahb.hready && (htrans_q != HTRANS_IDLE);
  assign dph_ok   = dphase_q && ahb.hready && (ahb.hresp == HRESP_OKAY);
  assign err1     = dphase_q && !ahb.hready && (ahb.hresp == HRESP_ERROR);
  assign len_eff  = (cmd_len == '0) ? LEN_W'(1) : cmd_len;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q;

  assign to_hit   = (state_q != ST_IDLE) && !ahb.hready &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign to_cnt_d = ((state_q == ST_IDLE) || ahb.hready) ? '0 : to_cnt_q + TO_W'(1);
  assign timeout  = timeout_q;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_hit ? '0 : to_cnt_d;
      timeout_q <= to_hit;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = cmd_fire ? ST_ADDR : ST_IDLE;
      ST_ADDR: begin
        if (err1)                                  state_d = ST_ERR2;
        else if (beat_acc && rem_q == LEN_W'(1))   state_d = ST_LAST;
        else                                       state_d = ST_ADDR;
      end
      ST_LAST: begin
        if (err1)              state_d = ST_ERR2;
        else if (ahb.hready)   state_d = ST_IDLE;
        else                   state_d = ST_LAST;
      end
      ST_ERR2: state_d = ahb.hready ? ST_IDLE : ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    if (to_hit) state_d = ST_IDLE;
  end

  always_comb begin
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    rem_d      = rem_q;
    dphase_d   = ahb.hready ? beat_acc : dphase_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (cmd_fire) begin
      haddr_d  = cmd_addr;
      htrans_d = HTRANS_NONSEQ;
      hwrite_d = cmd_write;
      hburst_d = burst_for_len(32'(len_eff));
      rem_d    = len_eff;
    end else if (beat_acc) begin
      haddr_d  = haddr_q + 32'd4;
      htrans_d = (rem_q == LEN_W'(1)) ? HTRANS_IDLE : HTRANS_SEQ;
      rem_d    = rem_q - LEN_W'(1);
      if (hwrite_q) hwdata_d = wd_data;
    end else begin
      haddr_d = haddr_q;
    end

    // The beat in address phase during the first ERROR cycle is dropped.
    if (err1) begin
      htrans_d = HTRANS_IDLE;
      rem_d    = '0;
    end

    if (dph_ok && !hwrite_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ahb.hrdata;
    end

    if (ahb.hready && (state_q == ST_LAST || state_q == ST_ERR2)) begin
      done_d = 1'b1;
      err_d  = (state_q == ST_ERR2) || (ahb.hresp == HRESP_ERROR);
    end

    if (to_hit) begin
      htrans_d = HTRANS_IDLE;
      rem_d    = '0;
      dphase_d = 1'b0;
      done_d   = 1'b1;
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr_q    <= 32'h0;
      htrans_q   <= HTRANS_IDLE;
      hwrite_q   <= 1'b0;
      hburst_q   <= HBURST_SINGLE;
      hwdata_q   <= 32'h0;
      rem_q      <= '0;
      dphase_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      rem_q      <= rem_d;
      dphase_q   <= dphase_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign wd_pop     = beat_acc && hwrite_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign ahb.haddr  = haddr_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hwrite = hwrite_q;
  assign ahb.hsize  = HSIZE_WORD;
  assign ahb.hburst = hburst_q;
  assign ahb.hwdata = hwdata_q;

endmodule

// File: tb/tb_ahb_master_engine.sv
// Directed bench for ahb_master_engine; the bench acts as the AHB slave.
module tb_ahb_master_engine;
  import ahb_pkg::*;

  localparam int LEN_W = 5;

  logic             hclk = 1'b0;
  logic             hreset;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      wd_data;
  logic             wd_pop, rd_valid, done, err;
  logic [31:0]      rd_data;
`ifdef AHB_MASTER_TIMEOUT_EN
  logic             timeout;
`endif

  ahb_master_engine_if ahb ();

  ahb_master_engine #(
    .LEN_W(LEN_W),
`ifdef AHB_MASTER_TIMEOUT_EN
    .TIMEOUT_CYC(8)
`else
    .TIMEOUT_CYC(256)
`endif
  ) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_data(wd_data), .wd_pop(wd_pop),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
`ifdef AHB_MASTER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .ahb(ahb)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Let inputs settle, tally combinational strobes, advance one clock.
  task automatic step();
    #1;
    pop_cnt  += int'(wd_pop);
    done_cnt += int'(done);
    @(posedge hclk);
    #1;
  endtask

  task automatic fire(input logic wr, input logic [31:0] a, input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_len = '0; wd_data = 32'h0;
    ahb.hready = 1'b1; ahb.hresp = HRESP_OKAY; ahb.hrdata = 32'h0;
    step(); step();

    check("rst_haddr",  ahb.haddr, 32'h0);
    check("rst_htrans", 32'(ahb.htrans), 32'(HTRANS_IDLE));
    check("rst_hburst", 32'(ahb.hburst), 32'h0);
    check("rst_hwdata", ahb.hwdata, 32'h0);
    check("rst_rdv",    32'(rd_valid), 32'h0);
    check("rst_done",   32'(done), 32'h0);
    check("rst_ready",  32'(cmd_ready), 32'h1);
    check("hsize",      32'(ahb.hsize), 32'h2);
    hreset = 1'b0;
    step();

    // Single write
    wd_data = 32'hA5A5_0001;
    fire(1'b1, 32'h0000_0010, 5'd1);
    #1;
    check("w1_htrans", 32'(ahb.htrans), 32'(HTRANS_NONSEQ));
    check("w1_haddr",  ahb.haddr, 32'h0000_0010);
    check("w1_hburst", 32'(ahb.hburst), 32'(HBURST_SINGLE));
    check("w1_hwrite", 32'(ahb.hwrite), 32'h1);
    check("w1_pop",    32'(wd_pop), 32'h1);
    check("w1_rdy",    32'(cmd_ready), 32'h0);
    step();
    check("w1_hwdata", ahb.hwdata, 32'hA5A5_0001);
    check("w1_idle",   32'(ahb.htrans), 32'(HTRANS_IDLE));
    check("w1_nodone", 32'(done), 32'h0);
    step();
    check("w1_done",   32'(done), 32'h1);
    check("w1_err",    32'(err), 32'h0);
    check("w1_rdy2",   32'(cmd_ready), 32'h1);
    step();
    check("w1_done0",  32'(done), 32'h0);

    // INCR4 read with two wait states on the second beat's data phase
    fire(1'b0, 32'h8400_0000, 5'd4);
    check("r4_haddr0", ahb.haddr, 32'h8400_0000);
    check("r4_hburst", 32'(ahb.hburst), 32'(HBURST_INCR4));
    step();
    check("r4_haddr1", ahb.haddr, 32'h8400_0004);
    check("r4_seq",    32'(ahb.htrans), 32'(HTRANS_SEQ));
    ahb.hrdata = 32'hD000_0000;
    step();
    check("r4_rdv0",   32'(rd_valid), 32'h1);
    check("r4_rd0",    rd_data, 32'hD000_0000);
    check("r4_haddr2", ahb.haddr, 32'h8400_0008);
    ahb.hready = 1'b0; ahb.hrdata = 32'hDEAD_DEAD;
    step();
    check("r4_hold1",  ahb.haddr, 32'h8400_0008);
    check("r4_rdvw",   32'(rd_valid), 32'h0);
    step();
    check("r4_hold2",  ahb.haddr, 32'h8400_0008);
    check("r4_holdt",  32'(ahb.htrans), 32'(HTRANS_SEQ));
    ahb.hready = 1'b1; ahb.hrdata = 32'hD000_0001;
    step();
    check("r4_rd1",    rd_data, 32'hD000_0001);
    check("r4_haddr3", ahb.haddr, 32'h8400_000C);
    ahb.hrdata = 32'hD000_0002;
    step();
    check("r4_rd2",    rd_data, 32'hD000_0002);
    check("r4_idle",   32'(ahb.htrans), 32'(HTRANS_IDLE));
    ahb.hrdata = 32'hD000_0003;
    step();
    check("r4_rdv3",   32'(rd_valid), 32'h1);
    check("r4_rd3",    rd_data, 32'hD000_0003);
    check("r4_done",   32'(done), 32'h1);
    check("r4_err",    32'(err), 32'h0);
    step();

    // ERROR on the second beat of an 8-beat write
    pop_cnt = 0;
    wd_data = 32'hB000_0000;
    fire(1'b1, 32'h8800_0000, 5'd8);
    check("e8_hburst", 32'(ahb.hburst), 32'(HBURST_INCR));
    step();
    wd_data = 32'hB000_0001;
    step();
    check("e8_haddr",  ahb.haddr, 32'h8800_0008);
    ahb.hready = 1'b0; ahb.hresp = HRESP_ERROR;
    step();
    check("e8_idle",   32'(ahb.htrans), 32'(HTRANS_IDLE));
    check("e8_hwdata", ahb.hwdata, 32'hB000_0001);
    check("e8_nodone", 32'(done), 32'h0);
    ahb.hready = 1'b1;
    step();
    check("e8_done",   32'(done), 32'h1);
    check("e8_err",    32'(err), 32'h1);
    ahb.hresp = HRESP_OKAY;
    step(); step();
    check("e8_pops",   32'(pop_cnt), 32'd2);
    check("e8_idle2",  32'(ahb.htrans), 32'(HTRANS_IDLE));

    // Address wrap at the top of the 32-bit space
    fire(1'b0, 32'hFFFF_FFFC, 5'd2);
    check("wr_haddr0", ahb.haddr, 32'hFFFF_FFFC);
    check("wr_hburst", 32'(ahb.hburst), 32'(HBURST_INCR));
    step();
    check("wr_haddr1", ahb.haddr, 32'h0000_0000);
    step(); step();
    check("wr_done",   32'(done), 32'h1);
    step();

    // Zero length behaves as a single beat
    fire(1'b1, 32'h0000_0020, 5'd0);
    check("l0_hburst", 32'(ahb.hburst), 32'(HBURST_SINGLE));
    step();
    check("l0_idle",   32'(ahb.htrans), 32'(HTRANS_IDLE));
    step();
    check("l0_done",   32'(done), 32'h1);
    step();

    // Reset mid-burst abandons without done
    fire(1'b0, 32'h0000_0100, 5'd8);
    step();
    check("rb_seq",    32'(ahb.htrans), 32'(HTRANS_SEQ));
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    check("rb_idle",   32'(ahb.htrans), 32'(HTRANS_IDLE));
    check("rb_haddr",  ahb.haddr, 32'h0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) step();
    check("rb_nodone", 32'(done_cnt), 32'd0);
    check("rb_ready",  32'(cmd_ready), 32'h1);

`ifdef AHB_MASTER_TIMEOUT_EN
    // Slave stuck not-ready triggers the timeout
    fire(1'b0, 32'h0000_0200, 5'd1);
    ahb.hready = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) step();
    check("to_pre",    32'(done_cnt), 32'd0);
    check("to_tmo",    32'(timeout), 32'h1);
    check("to_done",   32'(done), 32'h1);
    check("to_err",    32'(err), 32'h1);
    check("to_idle",   32'(ahb.htrans), 32'(HTRANS_IDLE));
    ahb.hready = 1'b1;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
